da_lut_mac: RTL and testbench
=============================

DA_LUT_MAC -- requirements
Module: da_lut_mac

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of parallel input samples; LUT depth is 2^N_IN.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the two's-complement sample width.
REQ-003 The block SHALL have parameter COEF_W, default 17, meaning the two's-complement LUT word width.
REQ-004 The block SHALL have parameter OUT_W, default 24, meaning the output width.
REQ-005 The block SHALL have parameter FRAC, default 0, meaning the arithmetic right shift applied to the accumulator before output.
REQ-006 The block SHALL have a port clk, input, 1 bit: the single clock, rising-edge.
REQ-007 The block SHALL have a port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-008 The block SHALL have a port cs, input, 1 bit: chip select and global accept enable.
REQ-009 The block SHALL have a port cfg_we, input, 1 bit: LUT write strobe.
REQ-010 The block SHALL have a port cfg_addr, input, N_IN bits: LUT write address.
REQ-011 The block SHALL have a port cfg_data, input, COEF_W bits: LUT write data.
REQ-012 The block SHALL have a port in_valid, input, 1 bit: sample vector valid.
REQ-013 The block SHALL have a port in_ready, output, 1 bit: sample vector accepted this cycle.
REQ-014 The block SHALL have a port in_data, input, N_IN*DATA_W bits: samples, where x_i occupies bits [i*DATA_W +: DATA_W].
REQ-015 The block SHALL have a port out_valid, output, 1 bit: result valid.
REQ-016 The block SHALL have a port out_ready, input, 1 bit: downstream accepts result.
REQ-017 The block SHALL have a port out_data, output, OUT_W bits: two's-complement result.

Function
REQ-018 The block SHALL hold a 2^N_IN x COEF_W register LUT; the LUT is written on a clock edge when cfg_we=1, cs=1 and state=IDLE, and writes in any other state SHALL be dropped.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on in_valid&&in_ready; RUN->DONE after DATA_W RUN cycles; DONE->IDLE on out_ready.
REQ-020 in_ready SHALL be combinational and equal (state==IDLE)&&cs; cs=0 SHALL NOT stall RUN or DONE.
REQ-021 On acceptance, the block SHALL latch in_data, clear the accumulator (ACC_W=COEF_W+DATA_W+1) and clear the bit counter.
REQ-022 In RUN cycle b (b=0..DATA_W-1), the LUT address SHALL be {x_{N_IN-1}[b],...,x_0[b]}, and the block SHALL add the sign-extended LUT word shifted left by b to the accumulator, or subtract it when b=DATA_W-1.
REQ-023 out_valid SHALL rise on the DATA_W-th edge after the acceptance edge and hold, with out_data stable, until out_valid&&out_ready.
REQ-024 out_data SHALL equal the accumulator arithmetically shifted right by FRAC and reduced to OUT_W as defined in REQ-028.
REQ-025 Throughput SHALL be one result per DATA_W+2 cycles when out_ready=1.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, accumulator=0, bit counter=0 and all LUT words=0, including mid-RUN or mid-DONE, with no result emitted.
REQ-027 Reset deassertion SHALL pass through a two-flop synchronizer, and in_ready SHALL remain 0 until the synchronized reset releases.

Configuration
REQ-028 With macro DA_LUT_MAC_SAT_EN defined, the shifted accumulator SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; without the macro, it SHALL be truncated to its low OUT_W bits (wrap).

Verification
REQ-029 Reset check: hold rst_n=0 then release -> out_valid=0, out_data=0, and in_ready=1 with cs=1 two cycles after release.
REQ-030 Single-term check: LUT[1]=100, x0=3, others 0 -> out_data=300 with out_valid rising 8 edges after acceptance.
REQ-031 Negative-sample check: LUT[1]=100, x0=-1 (0xFF) -> out_data=-100, exercising the MSB subtract.
REQ-032 All-lanes check: LUT[15]=50, all x_i=-128 -> out_data=-6400.
REQ-033 Saturation check: OUT_W=12, LUT[1]=2000, x0=127 -> 2047 with DA_LUT_MAC_SAT_EN, 48 without.
REQ-034 Backpressure and reset check: hold out_ready=0 for 5 cycles -> out_data held and in_ready=0; assert rst_n=0 mid-RUN -> IDLE, out_valid never asserts, LUT reads 0.

Source files
------------

// File: rtl/da_lut_mac.sv
// da_lut_mac -- distributed-arithmetic multiply-accumulate.
//
// Computes out = sum_i( x_i * c_i ) bit-serially. Each x_i is a DATA_W-bit
// two's-complement sample. The coefficient combinations live in a
// 2^N_IN-entry LUT that the host programs through cfg_*. One result takes
// DATA_W RUN cycles. The most significant sample bit carries negative
// weight, so its partial product is subtracted.
//
// Build option: define DA_LUT_MAC_SAT_EN to saturate the output to the
// OUT_W range. When it is undefined, the output wraps (the high bits are
// truncated).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; its release is synchronised
//   cs         chip select; gates sample acceptance and LUT writes
//   cfg_we     LUT write strobe, honoured only in IDLE
//   cfg_addr   LUT write address
//   cfg_data   LUT write data (two's complement)
//   in_valid   sample vector valid
//   in_ready   sample vector accepted this cycle (combinational)
//   in_data    packed samples; x_i is at [i*DATA_W +: DATA_W]
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_data   result (two's complement)
module da_lut_mac #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 17,
    parameter int OUT_W  = 24,
    parameter int FRAC   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     cfg_we,
    input  logic [N_IN-1:0]          cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data
);

    localparam int          ACC_W = COEF_W + DATA_W + 1;
    localparam int unsigned DEPTH = 1 << N_IN;
    localparam int          CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [1:0]                rst_pipe;
    logic                      rst_sync_n;
    logic [COEF_W-1:0]         lut [DEPTH];
    logic [N_IN*DATA_W-1:0]    x_reg;
    logic [CNT_W-1:0]          bit_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   term_sh;
    logic signed [ACC_W-1:0]   acc_shr;
    logic [N_IN-1:0]           lut_addr;
    logic [COEF_W-1:0]         lut_word;
    logic [OUT_W-1:0]          out_res;
    logic                      accept;
    logic                      last_bit;
    logic                      lut_we;

    // Reset asserts asynchronously and releases after two clock edges.
    // The core flops still reset directly from rst_n. Acceptance is held
    // off until the synchronised release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_sync_n = rst_pipe[1];

    assign in_ready  = (state == IDLE) && cs && rst_sync_n;
    assign accept    = in_valid && in_ready;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign out_valid = (state == DONE);
    assign lut_we    = cfg_we && cs && (state == IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Coefficient LUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                lut[k] <= '0;
            end
        end else if (lut_we) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

    // The LUT address is formed from bit b of every lane, with lane i
    // supplying address bit i.
    always_comb begin
        lut_addr = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            lut_addr[i] = x_reg[i*DATA_W + 32'(bit_cnt)];
        end
    end

    assign lut_word = lut[lut_addr];
    assign term     = ACC_W'($signed(lut_word));
    assign term_sh  = term <<< bit_cnt;
    assign acc_nxt  = last_bit ? (acc - term_sh) : (acc + term_sh);
    assign acc_shr  = acc_nxt >>> FRAC;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                x_reg   <= in_data;
                acc     <= '0;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                acc     <= acc_nxt;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                // Capture from acc_nxt so the result is ready on the same
                // edge that enters DONE.
                if (last_bit) begin
                    out_data <= out_res;
                end
            end
        end
    end

    // Reduce the shifted accumulator to OUT_W bits.
    generate
        if (OUT_W >= ACC_W) begin : g_wide
            assign out_res = OUT_W'(acc_shr);
        end else begin : g_narrow
`ifdef DA_LUT_MAC_SAT_EN
            // The value fits only if every bit from OUT_W-1 upward equals
            // the sign bit.
            logic [ACC_W-OUT_W:0] hi;
            assign hi = acc_shr[ACC_W-1:OUT_W-1];
            always_comb begin
                out_res = acc_shr[OUT_W-1:0];
                if (!((&hi) || !(|hi))) begin
                    out_res = acc_shr[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                               : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
`else
            logic unused_hi;
            assign unused_hi = ^acc_shr[ACC_W-1:OUT_W];
            assign out_res   = acc_shr[OUT_W-1:0];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_da_lut_mac.sv
module tb_da_lut_mac;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [16:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [11:0] s_out_data;

    int total = 0;
    int bad   = 0;
    int lat;
    int cnt;

    da_lut_mac dut (
        .clk(clk), .rst_n(rst_n), .cs(cs),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Narrow-output twin driven by the same inputs.
    da_lut_mac #(.OUT_W(12)) dut_s (
        .clk(clk), .rst_n(rst_n), .cs(cs),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_wr(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = 17'(d);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic start(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        chk("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            l++;
            if (out_valid) break;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("take_valid_low", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset state and synchronised release
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        cs = 1'b1;
        chk("rst_in_ready_held", in_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("rel1_in_ready", in_ready, 0);
        tick();
        chk("rel2_in_ready", in_ready, 1);

        // single term: LUT[1]=100, x0=3
        lut_wr(1, 100);
        start(32'h0000_0003);
        wait_out(lat);
        chk("single_latency", lat, 8);
        chk("single_data", $signed(out_data), 300);
        take();

        // negative sample exercises the MSB subtract
        start(32'h0000_00FF);
        wait_out(lat);
        chk("neg_latency", lat, 8);
        chk("neg_data", $signed(out_data), -100);
        take();

        // all lanes at -128
        lut_wr(15, 50);
        start(32'h8080_8080);
        wait_out(lat);
        chk("all_lanes_data", $signed(out_data), -6400);
        take();

        // wide vs narrow output, positive and negative overflow
        lut_wr(1, 2000);
        start(32'h0000_007F);
        wait_out(lat);
        chk("big_pos_wide", $signed(out_data), 254000);
`ifdef DA_LUT_MAC_SAT_EN
        chk("big_pos_narrow", $signed(s_out_data), 2047);
`else
        chk("big_pos_narrow", $signed(s_out_data), 48);
`endif
        take();
        start(32'h0000_0081);
        wait_out(lat);
        chk("big_neg_wide", $signed(out_data), -254000);
`ifdef DA_LUT_MAC_SAT_EN
        chk("big_neg_narrow", $signed(s_out_data), -2048);
`else
        chk("big_neg_narrow", $signed(s_out_data), -48);
`endif
        take();

        // backpressure: result held while out_ready=0
        start(32'h0000_0003);
        wait_out(lat);
        chk("bp_latency", lat, 8);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", $signed(out_data), 6000);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);

        // throughput: back-to-back with out_ready held high
        tick();
        chk("tp_busy", in_ready, 0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            cnt++;
            if (in_ready) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("tp_period", cnt, 9);
        chk("tp_data", $signed(out_data), 6000);

        // cs=0 during RUN does not stall; LUT write in RUN is dropped
        start(32'h0000_0001);
        lat = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            lat++;
            if (lat == 2) begin
                cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 17'd999;
            end
            if (lat == 3) begin
                cfg_we = 1'b0;
                cs     = 1'b0;
            end
            if (out_valid) break;
        end
        chk("cs_low_latency", lat, 8);
        chk("cs_low_data", $signed(out_data), 2000);
        take();
        chk("cs_low_idle_ready", in_ready, 0);
        cs = 1'b1;
        #1;
        chk("cs_high_idle_ready", in_ready, 1);
        start(32'h0000_0001);
        wait_out(lat);
        chk("run_write_dropped", $signed(out_data), 2000);
        take();

        // reset mid-RUN: no result emitted, LUT cleared
        start(32'h0000_0003);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_data", $signed(out_data), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("midrst_no_result", cnt, 0);
        chk("midrst_ready_after", in_ready, 1);
        start(32'h0000_0003);
        wait_out(lat);
        chk("lut_cleared_latency", lat, 8);
        chk("lut_cleared_data", $signed(out_data), 0);
        chk("lut_cleared_narrow", $signed(s_out_data), 0);
        take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
